bt_pipe_out_buffer: RTL
=======================

Name: bt_pipe_out_buffer

Overview:
User-side data source for a block-throttled pipe-out endpoint (host reads). User logic pushes 16-bit words into an internal FIFO. The block serves them to the endpoint's ep_read/ep_datain interface and asserts ep_ready only when a full block is buffered. It is the transmit-direction counterpart of the pipe-in consumer path and sits between acquisition logic and the okBTPipeOut instance on ti_clk.

Parameters:
ADDR_W, 10, log2 of FIFO depth (depth = 2**ADDR_W words)
BLOCK_WORDS, 256, words per host block transfer; power of two, 2..2**ADDR_W

Ports:
ti_clk  input  1  host-interface clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of FIFO, state and sticky flags
wr_en  input  1  user write strobe
wr_data  input  16  user write data
wr_full  output  1  FIFO full; a write while high is dropped
fill_count  output  ADDR_W+1  words currently stored
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: ep_read while FIFO empty
ep_read  input  1  from endpoint: consume one word
ep_blockstrobe  input  1  from endpoint: one-cycle pulse before a block transfer
ep_datain  output  16  data to endpoint
ep_ready  output  1  to endpoint: a full block is committed and available

Behaviour:
- Reset (async, rst_n=0): pointers=0, fill_count=0, ep_datain=16'h0000, ep_ready=0, wr_full=0, overflow=0, underflow=0, state=IDLE.
- FIFO: circular RAM with 2**ADDR_W entries; pointers ADDR_W+1 bits wide, wrap naturally. full = MSBs differ and low bits equal. empty = pointers equal.
- Write: wr_en & ~full stores wr_data at wptr and increments wptr. wr_en & full drops the data and sets overflow.
- Read latency is 1: on an edge with ep_read=1 and FIFO non-empty, ep_datain <= mem[rptr] and rptr increments. The word is valid in the cycle after ep_read. ep_datain holds its value otherwise.
- ep_read while empty: ep_datain <= 16'h0000, rptr unchanged, underflow set.
- Simultaneous write and read: both take effect; fill_count unchanged. A read on an empty FIFO does not see a same-cycle write (no bypass).
- fill_count = wptr - rptr, registered, updated the same edge as the pointers.
- Block FSM:
  - IDLE: ep_ready = (fill_count >= BLOCK_WORDS). ep_blockstrobe -> BURST, load blk_cnt = BLOCK_WORDS.
  - BURST: ep_ready=0. Each ep_read decrements blk_cnt. When blk_cnt reaches 0 -> IDLE. ep_blockstrobe in BURST restarts blk_cnt at BLOCK_WORDS; this is a protocol violation and the FSM stays in BURST.
- ep_ready is registered. It is evaluated from the post-update fill_count, so it rises 1 cycle after the BLOCK_WORDS-th word is written.
- ep_blockstrobe in IDLE with ep_ready=0 still enters BURST. Any resulting empty reads set underflow.
- wr_full is registered and equals full after the current edge.
- clear: same effect as reset but synchronous. It wins over a same-cycle wr_en or ep_read.
- Reset or clear mid-BURST: returns to IDLE and discards data. The host sees underflow-filled data; this is not this block's concern.

Decomposition:
- Shared package: FIFO data width constant (16) and FSM state encoding (IDLE, BURST).
- One sub-module, bt_fifo_ram: simple dual-port RAM with sync write and registered sync read, inferable as block RAM.
- Pointers, flags and FSM stay in the top module.

Test Plan:
- Reset release, write 255 words -> ep_ready=0, fill_count=255. Write the 256th word -> ep_ready=1 exactly 1 cycle later.
- From that state, blockstrobe then 256 ep_read pulses with data 0..255 -> ep_datain=k in the cycle after the k-th read, ep_ready=0 during BURST, fill_count=0 and IDLE at end.
- Fill to 1024, write 0xBEEF -> wr_full=1, overflow=1, the word is not stored, and the final read data excludes 0xBEEF.
- Concurrent write and read every cycle for 2000 cycles with 300 words preloaded -> fill_count stays 300, output order matches input across pointer wrap.
- ep_read on empty FIFO -> ep_datain=0x0000 next cycle, underflow=1, fill_count=0.
- Assert rst_n=0 mid-BURST after 100 reads -> all outputs at reset values immediately (asynchronous). After release, FSM=IDLE and the next 256 writes re-arm ep_ready.

Source files
------------

// File: rtl/bt_pipe_out_buffer_pkg.sv
// Shared constants and block-FSM encoding for the block-throttled pipe-out buffer.
package bt_pipe_out_buffer_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } blk_state_t;

endpackage

// File: rtl/bt_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read (block-RAM style).
module bt_fifo_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bt_pipe_out_buffer.sv
// User-side FIFO feeding a block-throttled pipe-out endpoint; ep_ready is raised
// only while a whole block is buffered and no block transfer is in flight.
module bt_pipe_out_buffer
  import bt_pipe_out_buffer_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic              ti_clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic [ADDR_W:0]   fill_count,
  output logic              overflow,
  output logic              underflow,
  input  logic              ep_read,
  input  logic              ep_blockstrobe,
  output logic [DATA_W-1:0] ep_datain,
  output logic              ep_ready
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
  localparam logic [PTR_W-1:0] DEPTH   = PTR_W'(2**ADDR_W);
  localparam logic [PTR_W-1:0] BLK_LVL = PTR_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] BLK_CNT = CNT_W'(BLOCK_WORDS);

  logic [PTR_W-1:0]  wptr, rptr, wptr_nxt, rptr_nxt, fill_nxt;
  logic              empty, full, wr_ok, rd_ok;
  blk_state_t        state, state_nxt;
  logic [CNT_W-1:0]  blk_cnt, blk_cnt_nxt;
  logic              dat_zero;
  logic [DATA_W-1:0] ram_q;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                    (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign wr_ok    = wr_en & ~full & ~clear;
  assign rd_ok    = ep_read & ~empty & ~clear;
  assign wptr_nxt = wptr + PTR_W'(wr_ok);
  assign rptr_nxt = rptr + PTR_W'(rd_ok);
  assign fill_nxt = wptr_nxt - rptr_nxt;

  bt_fifo_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (ti_clk),
    .wr_en   (wr_ok),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_ok),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  // Block FSM: every host read inside a burst counts, even one that underflows.
  always_comb begin
    state_nxt   = state;
    blk_cnt_nxt = blk_cnt;
    case (state)
      ST_IDLE: begin
        if (ep_blockstrobe) begin
          state_nxt   = ST_BURST;
          blk_cnt_nxt = BLK_CNT;
        end
      end
      ST_BURST: begin
        if (ep_blockstrobe) begin
          blk_cnt_nxt = BLK_CNT;
        end else if (ep_read) begin
          blk_cnt_nxt = blk_cnt - CNT_W'(1);
          if (blk_cnt == CNT_W'(1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_count <= '0;
      wr_full    <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ep_ready   <= 1'b0;
      state      <= ST_IDLE;
      blk_cnt    <= '0;
      dat_zero   <= 1'b1;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_count <= '0;
      wr_full    <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ep_ready   <= 1'b0;
      state      <= ST_IDLE;
      blk_cnt    <= '0;
      dat_zero   <= 1'b1;
    end else begin
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      fill_count <= fill_nxt;
      wr_full    <= (fill_nxt == DEPTH);
      overflow   <= overflow | (wr_en & full);
      underflow  <= underflow | (ep_read & empty);
      ep_ready   <= (state_nxt == ST_IDLE) && (fill_nxt >= BLK_LVL);
      state      <= state_nxt;
      blk_cnt    <= blk_cnt_nxt;
      if (rd_ok)                dat_zero <= 1'b0;
      else if (ep_read & empty) dat_zero <= 1'b1;
    end
  end

  // The RAM read register carries no reset; the zero flag masks it after reset,
  // clear and empty reads, and both hold between reads.
  assign ep_datain = dat_zero ? '0 : ram_q;

endmodule
